// File: rtl/player_pkg.sv
// Shared types, default field geometry and object-word packing for the player motion controller.
// Latency: none (package only).
// Backpressure: not applicable.
package player_pkg;

    // Player state machine encoding
    typedef enum logic [2:0] {
        ST_TITLE = 3'd0,
        ST_RUN   = 3'd1,
        ST_DUCK  = 3'd2,
        ST_RISE  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_FALL  = 3'd5
    } state_t;

    // Default object-word field widths
    localparam int DEF_X_W    = 10;
    localparam int DEF_Y_W    = 10;
    localparam int DEF_WH_W   = 8;
    localparam int DEF_TYPE_W = 6;

    // Fixed object types shared with the renderer
    localparam int DEF_DUCK_TYPE  = 8;
    localparam int DEF_JUMP_TYPE  = 9;
    localparam int DEF_TITLE_TYPE = 0;

    // Widest object word the packing helper supports
    localparam int WORD_MAX = 128;
    typedef logic [WORD_MAX-1:0] word_t;

    // Keep only the low w bits of a field value, widened to a full word
    function automatic word_t fmask(input logic [31:0] v, input int w);
        word_t m;
        m = (word_t'(1) << w) - word_t'(1);
        return word_t'(v) & m;
    endfunction

    // Pack {type, height, width, y, x} with x in the least significant bits
    function automatic word_t pack_obj(input logic [31:0] tp, input logic [31:0] h,
                                       input logic [31:0] wd, input logic [31:0] y,
                                       input logic [31:0] x, input int type_w,
                                       input int wh_w, input int y_w, input int x_w);
        return (fmask(tp, type_w) << (2*wh_w + y_w + x_w))
             | (fmask(h,  wh_w)   << (wh_w + y_w + x_w))
             | (fmask(wd, wh_w)   << (y_w + x_w))
             | (fmask(y,  y_w)    << x_w)
             |  fmask(x,  x_w);
    endfunction

    // RISE/HOLD/FALL are the airborne phases
    function automatic logic is_airborne(input state_t s);
        return (s == ST_RISE) || (s == ST_HOLD) || (s == ST_FALL);
    endfunction

endpackage

// File: rtl/player_motion_ctrl_anim_counter.sv
// Run-animation frame sequencer: fcnt counts ticks per frame, frame wraps over the frame count.
// Latency: frame_next is the combinational value the frame register takes at the next edge.
// Backpressure: none; en low holds both counters, clr forces them to zero.
module anim_counter #(
    parameter int FRAMES       = 3,
    parameter int FRAME_PERIOD = 5,
    parameter int FR_W         = 2
) (
    input  logic            clk3,
    input  logic            reset,
    input  logic            en,
    input  logic            clr,
    output logic [FR_W-1:0] frame_next
);

    localparam int FC_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

    logic [FR_W-1:0] frame;
    logic [FC_W-1:0] fcnt;
    logic [FC_W-1:0] fcnt_next;

    // Advance the tick counter, stepping the frame each time it wraps
    always_comb begin
        frame_next = frame;
        fcnt_next  = fcnt;
        if (clr) begin
            frame_next = '0;
            fcnt_next  = '0;
        end else if (en) begin
            if (fcnt == FC_W'(FRAME_PERIOD-1)) begin
                fcnt_next  = '0;
                frame_next = (frame == FR_W'(FRAMES-1)) ? '0 : frame + 1'b1;
            end else begin
                fcnt_next = fcnt + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            frame <= '0;
            fcnt  <= '0;
        end else begin
            frame <= frame_next;
            fcnt  <= fcnt_next;
        end
    end

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-tick player motion FSM producing the packed player/title object word plus airborne/landed flags.
// Latency: all outputs registered; they reflect the inputs seen at the previous clk3 edge.
// Backpressure: none; pause freezes state and word, start low forces the title object.
module player_motion_ctrl
    import player_pkg::*;
#(
    parameter int X_W          = DEF_X_W,
    parameter int Y_W          = DEF_Y_W,
    parameter int WH_W         = DEF_WH_W,
    parameter int TYPE_W       = DEF_TYPE_W,
    parameter int RISE_TICKS   = 8,
    parameter int HOLD_TICKS   = 16,
    parameter int FALL_TICKS   = 8,
    parameter int MAX_H        = 64,
    parameter int Y_GROUND     = 200,
    parameter int PLAYER_X     = 40,
    parameter int RUN_W        = 32,
    parameter int RUN_H        = 32,
    parameter int DUCK_H       = 16,
    parameter int FRAME_BASE   = 4,
    parameter int FRAMES       = 3,
    parameter int FRAME_PERIOD = 5,
    parameter int DUCK_TYPE    = DEF_DUCK_TYPE,
    parameter int JUMP_TYPE    = DEF_JUMP_TYPE,
    parameter int TITLE_TYPE   = DEF_TITLE_TYPE,
    parameter int TITLE_X      = 100,
    parameter int TITLE_Y      = 80,
    parameter int TITLE_W      = 120,
    parameter int TITLE_H      = 40,
    localparam int DATA_W      = TYPE_W + 2*WH_W + Y_W + X_W
) (
    input  logic              clk3,
    input  logic              reset,
    input  logic              pause,
    input  logic              start,
    input  logic              jump_n,
    input  logic              duck_n,
    output logic [DATA_W-1:0] player,
    output logic              airborne,
    output logic              landed
);

    localparam int MAXT   = (RISE_TICKS > FALL_TICKS)
                          ? ((RISE_TICKS > HOLD_TICKS) ? RISE_TICKS : HOLD_TICKS)
                          : ((FALL_TICKS > HOLD_TICKS) ? FALL_TICKS : HOLD_TICKS);
    // One spare bit: an early release at the very first rise tick resumes at FALL_TICKS
    localparam int CNT_W  = $clog2(MAXT) + 1;
    localparam int FR_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int RSTEP  = MAX_H / RISE_TICKS;
    localparam int FSTEP  = MAX_H / FALL_TICKS;

    localparam logic [DATA_W-1:0] TITLE_WORD =
        DATA_W'(pack_obj(32'(TITLE_TYPE), 32'(TITLE_H), 32'(TITLE_W), 32'(TITLE_Y),
                         32'(TITLE_X), TYPE_W, WH_W, Y_W, X_W));

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              jump_prev;
    logic              press;
    logic              rel;
    logic              land_nxt;
    logic              air_nxt;
    logic [DATA_W-1:0] player_nxt;
    logic [FR_W-1:0]   frame_next;
    logic              anim_en;
    logic              anim_clr;
    int                y_v;
    int                h_v;
    int                tp_v;

    assign press    = jump_prev & ~jump_n;
    assign rel      = ~jump_prev & jump_n;
    assign anim_en  = start & ~pause & ((state == ST_RUN) || (state == ST_DUCK));
    assign anim_clr = ~start;

    anim_counter #(
        .FRAMES       (FRAMES),
        .FRAME_PERIOD (FRAME_PERIOD),
        .FR_W         (FR_W)
    ) u_anim (
        .clk3       (clk3),
        .reset      (reset),
        .en         (anim_en),
        .clr        (anim_clr),
        .frame_next (frame_next)
    );

    // State, counter, edge-detect and registered outputs; the button history loads the live input at reset
    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            state     <= ST_TITLE;
            cnt       <= '0;
            jump_prev <= jump_n;
            player    <= TITLE_WORD;
            airborne  <= 1'b0;
            landed    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            jump_prev <= jump_n;
            player    <= player_nxt;
            airborne  <= air_nxt;
            landed    <= land_nxt;
        end
    end

    // Next state and phase counter; start low wins, then pause, then the jump/duck rules
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        land_nxt  = 1'b0;
        if (!start) begin
            state_nxt = ST_TITLE;
            cnt_nxt   = '0;
        end else if (!pause) begin
            case (state)
                ST_TITLE: begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
                ST_RUN: begin
                    if (press) begin
                        state_nxt = ST_RISE;
                        cnt_nxt   = '0;
                    end else if (!duck_n) begin
                        state_nxt = ST_DUCK;
                    end
                end
                ST_DUCK: begin
                    if (press) begin
                        state_nxt = ST_RISE;
                        cnt_nxt   = '0;
                    end else if (duck_n) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RISE: begin
                    if (rel) begin
                        // Early release: enter the fall at the matching point of its own timeline
                        state_nxt = ST_FALL;
                        cnt_nxt   = CNT_W'(FALL_TICKS - (int'(cnt) * FALL_TICKS) / RISE_TICKS);
                    end else if (cnt == CNT_W'(RISE_TICKS-1)) begin
                        state_nxt = (HOLD_TICKS == 0) ? ST_FALL : ST_HOLD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (rel || (cnt == CNT_W'(HOLD_TICKS-1))) begin
                        state_nxt = ST_FALL;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_FALL: begin
                    // >= so a fall resumed past the last tick still lands
                    if (cnt >= CNT_W'(FALL_TICKS-1)) begin
                        state_nxt = duck_n ? ST_RUN : ST_DUCK;
                        cnt_nxt   = '0;
                        land_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_TITLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Object word and airborne flag computed from the upcoming state, counter and frame
    always_comb begin
        y_v        = Y_GROUND;
        h_v        = RUN_H;
        tp_v       = FRAME_BASE + int'(frame_next);
        player_nxt = player;
        air_nxt    = airborne;
        if (!start) begin
            player_nxt = TITLE_WORD;
            air_nxt    = 1'b0;
        end else if (!pause) begin
            case (state_nxt)
                ST_DUCK: begin
                    y_v  = Y_GROUND + RUN_H - DUCK_H;
                    h_v  = DUCK_H;
                    tp_v = DUCK_TYPE;
                end
                ST_RISE: begin
                    y_v  = Y_GROUND - (int'(cnt_nxt) + 1) * RSTEP;
                    tp_v = JUMP_TYPE;
                end
                ST_HOLD: begin
                    y_v  = Y_GROUND - MAX_H;
                    tp_v = JUMP_TYPE;
                end
                ST_FALL: begin
                    y_v  = Y_GROUND - MAX_H + (int'(cnt_nxt) + 1) * FSTEP;
                    if (y_v > Y_GROUND) begin
                        y_v = Y_GROUND;
                    end
                    tp_v = JUMP_TYPE;
                end
                default: begin
                    y_v = Y_GROUND;
                end
            endcase
            air_nxt = is_airborne(state_nxt);
            if (state_nxt == ST_TITLE) begin
                player_nxt = TITLE_WORD;
            end else begin
                player_nxt = DATA_W'(pack_obj(32'(tp_v), 32'(h_v), 32'(RUN_W), 32'(y_v),
                                              32'(PLAYER_X), TYPE_W, WH_W, Y_W, X_W));
            end
        end
    end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: directed vector table plus randomized run against a reference model.
// Latency: outputs checked 1 time unit after each clk3 rising edge.
// Backpressure: not applicable.
module tb_player_motion_ctrl;

    localparam int RISE_T = 8;
    localparam int HOLD_T = 16;
    localparam int FALL_T = 8;
    localparam int MAXH   = 64;
    localparam int YG     = 200;
    localparam int FB     = 4;
    localparam int NFR    = 3;
    localparam int FPER   = 5;

    localparam int M_TITLE = 0;
    localparam int M_RUN   = 1;
    localparam int M_DUCK  = 2;
    localparam int M_RISE  = 3;
    localparam int M_HOLD  = 4;
    localparam int M_FALL  = 5;

    logic        clk3;
    logic        reset;
    logic        pause;
    logic        start;
    logic        jump_n;
    logic        duck_n;
    logic [41:0] player;
    logic        airborne;
    logic        landed;

    int checks;
    int errors;

    // Reference model state
    int m_mode;
    int m_t;
    int m_anim;
    bit m_jprev;
    bit m_land;

    typedef struct {
        bit p;
        bit s;
        bit j;
        bit d;
        int y;
        int h;
        int tp;
        bit air;
        bit land;
    } vec_t;

    vec_t tbl[$];

    player_motion_ctrl dut (
        .clk3     (clk3),
        .reset    (reset),
        .pause    (pause),
        .start    (start),
        .jump_n   (jump_n),
        .duck_n   (duck_n),
        .player   (player),
        .airborne (airborne),
        .landed   (landed)
    );

    initial clk3 = 1'b0;
    always #5 clk3 = ~clk3;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic void add(input bit p, input bit s, input bit j, input bit d,
                                input int y, input int h, input int tp,
                                input bit air, input bit land);
        vec_t v;
        v.p = p; v.s = s; v.j = j; v.d = d;
        v.y = y; v.h = h; v.tp = tp; v.air = air; v.land = land;
        tbl.push_back(v);
    endfunction

    // Expected object word from the model: height above ground in pixels, animation from total run ticks
    function automatic logic [41:0] model_word();
        int ht;
        int y;
        int h;
        int tp;
        if (m_mode == M_TITLE) begin
            return {6'd0, 8'd40, 8'd120, 10'd80, 10'd100};
        end
        ht = 0;
        h  = 32;
        tp = 9;
        case (m_mode)
            M_RUN:  tp = FB + (m_anim / FPER) % NFR;
            M_DUCK: begin tp = 8; h = 16; ht = -16; end
            M_RISE: ht = (m_t + 1) * (MAXH / RISE_T);
            M_HOLD: ht = MAXH;
            M_FALL: begin
                ht = MAXH - (m_t + 1) * (MAXH / FALL_T);
                if (ht < 0) ht = 0;
            end
            default: ht = 0;
        endcase
        y = YG - ht;
        return {tp[5:0], h[7:0], 8'd32, y[9:0], 10'd40};
    endfunction

    task automatic model_step(input bit p, input bit s, input bit j, input bit d);
        bit pr;
        bit rl;
        pr = m_jprev && !j;
        rl = !m_jprev && j;
        m_land = 1'b0;
        if (!s) begin
            m_mode = M_TITLE;
            m_t    = 0;
            m_anim = 0;
        end else if (!p) begin
            if (m_mode == M_RUN || m_mode == M_DUCK) m_anim++;
            case (m_mode)
                M_TITLE: m_mode = M_RUN;
                M_RUN: begin
                    if (pr) begin m_mode = M_RISE; m_t = 0; end
                    else if (!d) m_mode = M_DUCK;
                end
                M_DUCK: begin
                    if (pr) begin m_mode = M_RISE; m_t = 0; end
                    else if (d) m_mode = M_RUN;
                end
                M_RISE: begin
                    if (rl) begin
                        m_mode = M_FALL;
                        m_t    = FALL_T - m_t * FALL_T / RISE_T;
                    end else if (m_t == RISE_T - 1) begin
                        m_mode = (HOLD_T == 0) ? M_FALL : M_HOLD;
                        m_t    = 0;
                    end else begin
                        m_t++;
                    end
                end
                M_HOLD: begin
                    if (rl || m_t == HOLD_T - 1) begin m_mode = M_FALL; m_t = 0; end
                    else m_t++;
                end
                M_FALL: begin
                    if (m_t >= FALL_T - 1) begin
                        m_mode = d ? M_RUN : M_DUCK;
                        m_t    = 0;
                        m_land = 1'b1;
                    end else begin
                        m_t++;
                    end
                end
                default: m_mode = M_TITLE;
            endcase
        end
        m_jprev = j;
    endtask

    // Drive one tick of inputs, clock it in, then compare the DUT against the model
    task automatic step(input bit p, input bit s, input bit j, input bit d);
        pause  = p;
        start  = s;
        jump_n = j;
        duck_n = d;
        @(posedge clk3);
        #1;
        model_step(p, s, j, d);
        chk("model_word", 64'(player), 64'(model_word()));
        chk("model_airborne", 64'(airborne),
            64'(m_mode == M_RISE || m_mode == M_HOLD || m_mode == M_FALL));
        chk("model_landed", 64'(landed), 64'(m_land));
    endtask

    initial begin
        bit rj;
        bit rd;
        checks = 0;
        errors = 0;

        // Reset with start high: title word, flags low
        reset  = 1'b0;
        pause  = 1'b0;
        start  = 1'b1;
        jump_n = 1'b1;
        duck_n = 1'b1;
        m_mode = M_TITLE; m_t = 0; m_anim = 0; m_jprev = 1'b1; m_land = 1'b0;
        repeat (2) @(posedge clk3);
        #1;
        chk("reset_word", 64'(player), 64'({6'd0, 8'd40, 8'd120, 10'd80, 10'd100}));
        chk("reset_airborne", 64'(airborne), 64'(0));
        chk("reset_landed", 64'(landed), 64'(0));
        reset = 1'b1;

        // Full jump: title -> run, 8 rise, 16 hold, 8 fall, land
        add(0, 1, 1, 1, 200, 32, 4, 0, 0);
        for (int i = 0; i < 8; i++)  add(0, 1, 0, 1, 192 - 8*i, 32, 9, 1, 0);
        for (int i = 0; i < 16; i++) add(0, 1, 0, 1, 136, 32, 9, 1, 0);
        for (int i = 0; i < 8; i++)  add(0, 1, 0, 1, 144 + 8*i, 32, 9, 1, 0);
        add(0, 1, 0, 1, 200, 32, 4, 0, 1);
        add(0, 1, 1, 1, 200, 32, 4, 0, 0);
        // Early release after 4 rise ticks: fall resumes at cnt 8-3 = 5
        add(0, 1, 0, 1, 192, 32, 9, 1, 0);
        add(0, 1, 0, 1, 184, 32, 9, 1, 0);
        add(0, 1, 0, 1, 176, 32, 9, 1, 0);
        add(0, 1, 0, 1, 168, 32, 9, 1, 0);
        add(0, 1, 1, 1, 184, 32, 9, 1, 0);
        add(0, 1, 1, 1, 192, 32, 9, 1, 0);
        add(0, 1, 1, 1, 200, 32, 9, 1, 0);
        add(0, 1, 1, 1, 200, 32, 4, 0, 1);
        add(0, 1, 1, 1, 200, 32, 4, 0, 0);
        // Duck, jump from duck, release on the first rise tick (clamped fall), land back into duck
        add(0, 1, 1, 0, 216, 16, 8, 0, 0);
        add(0, 1, 0, 0, 192, 32, 9, 1, 0);
        add(0, 1, 1, 0, 200, 32, 9, 1, 0);
        add(0, 1, 1, 0, 216, 16, 8, 0, 1);
        add(0, 1, 1, 1, 200, 32, 5, 0, 0);
        // Pause mid-rise with jump toggling, then resume on the same trajectory
        add(0, 1, 0, 1, 192, 32, 9, 1, 0);
        add(0, 1, 0, 1, 184, 32, 9, 1, 0);
        add(0, 1, 0, 1, 176, 32, 9, 1, 0);
        for (int i = 0; i < 10; i++) add(1, 1, (i % 2 == 0) ? 1'b1 : 1'b0, 1, 176, 32, 9, 1, 0);
        for (int i = 0; i < 5; i++)  add(0, 1, 0, 1, 168 - 8*i, 32, 9, 1, 0);
        // start low mid-jump: title word next tick
        add(0, 0, 0, 1, 80, 40, 0, 0, 0);
        // Animation from a cleared counter: 4,5,6 for 5 ticks each, wrapping
        for (int k = 1; k <= 30; k++) add(0, 1, 1, 1, 200, 32, 4 + ((k - 1) / 5) % 3, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].p, tbl[i].s, tbl[i].j, tbl[i].d);
            chk($sformatf("vec%0d_y", i),    64'(player[19:10]), 64'(tbl[i].y));
            chk($sformatf("vec%0d_h", i),    64'(player[35:28]), 64'(tbl[i].h));
            chk($sformatf("vec%0d_type", i), 64'(player[41:36]), 64'(tbl[i].tp));
            chk($sformatf("vec%0d_air", i),  64'(airborne),      64'(tbl[i].air));
            chk($sformatf("vec%0d_land", i), 64'(landed),        64'(tbl[i].land));
        end

        // Randomized run against the model
        rj = 1'b1;
        rd = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom % 6 == 0)  rj = ~rj;
            if ($urandom % 12 == 0) rd = ~rd;
            step(($urandom % 8) == 0, ($urandom % 150) != 0, rj, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
